// File: rtl/alu_issue_stage.sv
// Registered RV32I decode/issue stage feeding the ALU's A/B/ALU_FUN interface.
// Defining ALU_ISSUE_SKID_EN adds a one-entry skid buffer with a registered IN_READY.
module alu_issue_stage (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] PC,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [3:0]  ALU_FUN,
    output logic        ILLEGAL
);

    typedef struct packed {
        logic        illegal;
        logic [3:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
    } issue_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_f7b;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immU;
    issue_t      w_dec;
    logic        w_accept;

    issue_t      r_out;
    logic        r_outValid;

    assign w_opcode = INSTR[6:0];
    assign w_f3     = INSTR[14:12];
    assign w_f7b    = INSTR[30];
    assign w_immI   = {{20{INSTR[31]}}, INSTR[31:20]};
    assign w_immS   = {{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
    assign w_immU   = {INSTR[31:12], 12'b0};

    always_comb begin
        w_dec = '0;
        case (w_opcode)
            OPC_OP: begin
                w_dec.a   = RS1_DATA;
                w_dec.b   = RS2_DATA;
                w_dec.fun = {w_f7b, w_f3};
            end
            OPC_OP_IMM: begin
                w_dec.a   = RS1_DATA;
                // Shifts carry only the 5-bit shamt; bit 30 selects arithmetic via FUN
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_dec.b = {27'b0, INSTR[24:20]};
                end else begin
                    w_dec.b = w_immI;
                end
                w_dec.fun = {(w_f3 == 3'b101) ? w_f7b : 1'b0, w_f3};
            end
            OPC_LOAD, OPC_JALR: begin
                w_dec.a = RS1_DATA;
                w_dec.b = w_immI;
            end
            OPC_STORE: begin
                w_dec.a = RS1_DATA;
                w_dec.b = w_immS;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    3'b000, 3'b001: begin
                        w_dec.a   = RS1_DATA;
                        w_dec.b   = RS2_DATA;
                        w_dec.fun = 4'b1000;
                    end
                    3'b100, 3'b101: begin
                        w_dec.a   = RS1_DATA;
                        w_dec.b   = RS2_DATA;
                        w_dec.fun = 4'b0010;
                    end
                    3'b110, 3'b111: begin
                        w_dec.a   = RS1_DATA;
                        w_dec.b   = RS2_DATA;
                        w_dec.fun = 4'b0011;
                    end
                    default: w_dec.illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_dec.a   = w_immU;
                w_dec.fun = 4'b1001;
            end
            OPC_AUIPC: begin
                w_dec.a = PC;
                w_dec.b = w_immU;
            end
            OPC_JAL: begin
                w_dec.a = PC;
                w_dec.b = 32'd4;
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

`ifdef ALU_ISSUE_SKID_EN
    issue_t r_skid;
    logic   r_skidFull;
    logic   w_outLoad;

    // IN_READY comes straight from a flop so OUT_READY never reaches it combinationally
    assign IN_READY  = !r_skidFull;
    assign w_accept  = IN_VALID && !r_skidFull;
    assign w_outLoad = !r_outValid || OUT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_outValid <= 1'b0;
            r_out      <= '0;
            r_skidFull <= 1'b0;
            r_skid     <= '0;
        end else if (w_outLoad) begin
            if (r_skidFull) begin
                r_out      <= r_skid;
                r_outValid <= 1'b1;
                r_skidFull <= 1'b0;
            end else if (w_accept) begin
                r_out      <= w_dec;
                r_outValid <= 1'b1;
            end else begin
                r_outValid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid     <= w_dec;
            r_skidFull <= 1'b1;
        end
    end
`else
    assign IN_READY = !r_outValid || OUT_READY;
    assign w_accept = IN_VALID && IN_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_outValid <= 1'b0;
            r_out      <= '0;
        end else if (w_accept) begin
            r_out      <= w_dec;
            r_outValid <= 1'b1;
        end else if (OUT_READY) begin
            r_outValid <= 1'b0;
        end
    end
`endif

    assign OUT_VALID = r_outValid;
    assign ALU_A     = r_out.a;
    assign ALU_B     = r_out.b;
    assign ALU_FUN   = r_out.fun;
    assign ILLEGAL   = r_out.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed RV32I vectors with hand-computed
// operands; accepted entries are queued and a negedge monitor checks issued payloads.
module tb_alu_issue_stage;

    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] INSTR;
    logic [31:0] PC;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ILLEGAL;

    int          checks = 0;
    int          errors = 0;
    int          acceptCount = 0;
    logic [68:0] expQ[$];
    logic        holdValid = 1'b0;
    logic [68:0] heldPayload;

    alu_issue_stage dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR(INSTR), .PC(PC), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_FUN(ALU_FUN), .ILLEGAL(ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [68:0] mk(input logic ill, input logic [3:0] fun,
                                       input logic [31:0] a, input logic [31:0] b);
        return {ill, fun, a, b};
    endfunction

    task automatic checkOutput(input string name, input logic [69:0] actual, input logic [69:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Offers one instruction for a single cycle; queues its expected result if taken
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [68:0] expected, output bit accepted);
        IN_VALID = 1'b1;
        INSTR    = instr;
        PC       = pc;
        RS1_DATA = rs1;
        RS2_DATA = rs2;
        @(negedge CLK);
        accepted = IN_READY;
        if (accepted) begin
            expQ.push_back(expected);
            acceptCount++;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic sendInstr(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [68:0] expected);
        bit ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) applyStimulus(instr, pc, rs1, rs2, expected, ok);
        checkOutput("accept within budget", {69'b0, ok}, 70'd1);
    endtask

    task automatic waitDrain();
        for (int t = 0; t < 50 && expQ.size() != 0; t++) @(negedge CLK);
        @(posedge CLK);
        #1;
        checkOutput("drain", 70'(expQ.size()), 70'd0);
    endtask

    // Monitor: a transfer happens at the next posedge when valid and ready are seen here
    always @(negedge CLK) begin
        if (!RST_N) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid)
                checkOutput("stall hold", {OUT_VALID, ILLEGAL, ALU_FUN, ALU_A, ALU_B}, {1'b1, heldPayload});
            if (OUT_VALID && OUT_READY) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected output: got %h expected none",
                             {ILLEGAL, ALU_FUN, ALU_A, ALU_B});
                end else begin
                    checkOutput("issue", {OUT_VALID, ILLEGAL, ALU_FUN, ALU_A, ALU_B}, {1'b1, expQ.pop_front()});
                end
            end
            holdValid   = OUT_VALID && !OUT_READY;
            heldPayload = {ILLEGAL, ALU_FUN, ALU_A, ALU_B};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int expAccepted;
        RST_N     = 1'b0;
        IN_VALID  = 1'b1;
        INSTR     = 32'h002081B3;
        PC        = 32'h0;
        RS1_DATA  = 32'd5;
        RS2_DATA  = 32'd7;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset state", {OUT_VALID, ILLEGAL, ALU_FUN, ALU_A, ALU_B}, 70'd0);
        IN_VALID = 1'b0;
        RST_N    = 1'b1;
        @(negedge CLK);
        checkOutput("in_ready after reset", {69'b0, IN_READY}, 70'd1);
        @(posedge CLK);
        #1;

        sendInstr(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(1'b0, 4'b0000, 32'd5, 32'd7));
        sendInstr(32'h402081B3, 32'h4, 32'd5, 32'd7, mk(1'b0, 4'b1000, 32'd5, 32'd7));
        sendInstr(32'h40315093, 32'h8, 32'hF0000000, 32'd0, mk(1'b0, 4'b1101, 32'hF0000000, 32'd3));
        sendInstr(32'h123450B7, 32'hC, 32'h0000AAAA, 32'd0, mk(1'b0, 4'b1001, 32'h12345000, 32'd0));
        sendInstr(32'hFFF00093, 32'h10, 32'h10, 32'd0, mk(1'b0, 4'b0000, 32'h10, 32'hFFFFFFFF));
        sendInstr(32'h00000000, 32'h14, 32'h55, 32'h66, mk(1'b1, 4'b0000, 32'd0, 32'd0));
        sendInstr(32'hFFF00093, 32'h18, 32'h10, 32'd0, mk(1'b0, 4'b0000, 32'h10, 32'hFFFFFFFF));
        sendInstr(32'hFE112E23, 32'h1C, 32'h100, 32'h22, mk(1'b0, 4'b0000, 32'h100, 32'hFFFFFFFC));
        sendInstr(32'h0020C463, 32'h20, 32'd3, 32'd9, mk(1'b0, 4'b0010, 32'd3, 32'd9));
        sendInstr(32'h00001517, 32'h400, 32'd0, 32'd0, mk(1'b0, 4'b0000, 32'h400, 32'h1000));
        sendInstr(32'h008000EF, 32'h800, 32'd0, 32'd0, mk(1'b0, 4'b0000, 32'h800, 32'd4));
        waitDrain();

`ifdef ALU_ISSUE_SKID_EN
        expAccepted = 2;
`else
        expAccepted = 1;
`endif
        acceptCount = 0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    sendInstr(32'h002081B3, 32'h100 + 32'(4 * i), 32'(10 + i), 32'(20 + i),
                              mk(1'b0, 4'b0000, 32'(10 + i), 32'(20 + i)));
            end
            begin
                OUT_READY = 1'b0;
                repeat (3) @(negedge CLK);
                #2;
                checkOutput("accepted during stall", 70'(acceptCount), 70'(expAccepted));
                checkOutput("in_ready stalled", {69'b0, IN_READY}, 70'd0);
                @(posedge CLK);
                #1;
                OUT_READY = 1'b1;
            end
        join
        waitDrain();

        OUT_READY = 1'b0;
        applyStimulus(32'h002081B3, 32'h200, 32'd1, 32'd2, mk(1'b0, 4'b0000, 32'd1, 32'd2), ok);
        applyStimulus(32'h002081B3, 32'h204, 32'd3, 32'd4, mk(1'b0, 4'b0000, 32'd3, 32'd4), ok);
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("reset mid-stall", {OUT_VALID, ILLEGAL, ALU_FUN, ALU_A, ALU_B}, 70'd0);
        checkOutput("in_ready in reset", {69'b0, IN_READY}, 70'd1);
        expQ.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST_N     = 1'b1;
        OUT_READY = 1'b1;
        sendInstr(32'h402081B3, 32'h300, 32'd50, 32'd8, mk(1'b0, 4'b1000, 32'd50, 32'd8));
        waitDrain();
        repeat (5) @(negedge CLK);
        checkOutput("no replay", 70'(expQ.size()), 70'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
